// File: rtl/coeff_pkg.sv
// Shared types and constants for the coefficient load sequencer.
package coeff_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_LOAD,
    ST_GAP,
    ST_DONE
  } coeff_ld_state_t;

  localparam int unsigned COEFF_SEL_W     = 2;
  localparam int unsigned COEFF_IN_W      = 16;
  localparam int unsigned COEFF_W_DEFAULT = 12;
  localparam int unsigned GAP_CNT_W       = 4;

  // Largest storable coefficient for a w-bit slot, expressed on the 16-bit bus.
  function automatic logic [COEFF_IN_W-1:0] coeff_max(input int unsigned w);
    logic [COEFF_IN_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < COEFF_IN_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/coeff_loader_gap_timer.sv
// Settle-gap down-counter: load, count down, zero flag.
module coeff_gap_timer
  import coeff_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [GAP_CNT_W-1:0] i_load_val,
  input  logic                 i_dec,
  output logic                 o_zero
);

  logic [GAP_CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/coeff_loader.sv
// Load sequencer: pulls coefficients from a valid/ready stream and writes
// them into slots 0..NUM_COEFF-1 with a settle gap between load pulses.
module coeff_loader
  import coeff_pkg::*;
#(
  parameter int unsigned NUM_COEFF  = 3,
  parameter int unsigned COEFF_W    = COEFF_W_DEFAULT,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COEFF_IN_W-1:0]  data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   coeff_ld,
  output logic [COEFF_SEL_W-1:0] coeff_sel,
  output logic [COEFF_IN_W-1:0]  coeff_in,
  output logic                   busy,
  output logic                   done,
  output logic                   range_err
);

  localparam logic [COEFF_SEL_W-1:0] LAST_IDX  = COEFF_SEL_W'(NUM_COEFF - 1);
  localparam logic [COEFF_IN_W-1:0]  COEFF_MAX = coeff_max(COEFF_W);
  // GAP spends one cycle per count including the zero cycle, hence the -1.
  localparam logic [GAP_CNT_W-1:0]   GAP_LOAD  =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  coeff_ld_state_t        r_state;
  coeff_ld_state_t        w_state_nxt;
  logic [COEFF_SEL_W-1:0] r_index;
  logic [COEFF_SEL_W-1:0] r_sel;
  logic [COEFF_IN_W-1:0]  r_coeff;
  logic                   r_range_err;

  logic w_capture;
  logic w_idx_clr;
  logic w_idx_inc;
  logic w_gap_load;
  logic w_gap_dec;
  logic w_gap_zero;

  coeff_gap_timer u_gap_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_gap_load),
    .i_load_val (GAP_LOAD),
    .i_dec      (w_gap_dec),
    .o_zero     (w_gap_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_idx_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_dec   = 1'b0;
    data_ready  = 1'b0;
    coeff_ld    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = ST_WAIT_DATA;
          w_idx_clr   = 1'b1;
        end
      end
      ST_WAIT_DATA: begin
        data_ready = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (data_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        coeff_ld = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_index == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_inc = 1'b1;
          if (GAP_CYCLES > 0) begin
            w_gap_load  = 1'b1;
            w_state_nxt = ST_GAP;
          end else begin
            w_state_nxt = ST_WAIT_DATA;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_gap_zero) begin
          w_state_nxt = ST_WAIT_DATA;
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index     <= '0;
      r_sel       <= '0;
      r_coeff     <= '0;
      r_range_err <= 1'b0;
    end else begin
      if (w_idx_clr) begin
        r_index     <= '0;
        r_range_err <= 1'b0;
      end else if (w_idx_inc) begin
        r_index <= r_index + 1'b1;
      end
      // Slot address is latched with the value so both stay put after the pulse.
      if (w_capture) begin
        r_sel <= r_index;
        if (data_in > COEFF_MAX) begin
          r_coeff     <= COEFF_MAX;
          r_range_err <= 1'b1;
        end else begin
          r_coeff <= data_in;
        end
      end
    end
  end

  assign coeff_sel = r_sel;
  assign coeff_in  = r_coeff;
  assign range_err = r_range_err;

endmodule

// File: tb/tb_coeff_loader.sv
// Scoreboard bench for coeff_loader: GAP_CYCLES=1 instance plus a GAP_CYCLES=0 instance.
module tb_coeff_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  sel;
    logic [15:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic        start, abort, data_valid;
  logic [15:0] data_in;
  logic        data_ready, coeff_ld, busy, done, range_err;
  logic [1:0]  coeff_sel;
  logic [15:0] coeff_in;

  logic        z_start, z_abort, z_data_valid;
  logic [15:0] z_data_in;
  logic        z_data_ready, z_coeff_ld, z_busy, z_done, z_range_err;
  logic [1:0]  z_coeff_sel;
  logic [15:0] z_coeff_in;

  coeff_loader #(.NUM_COEFF(3), .COEFF_W(12), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .coeff_ld(coeff_ld), .coeff_sel(coeff_sel), .coeff_in(coeff_in),
    .busy(busy), .done(done), .range_err(range_err)
  );

  coeff_loader #(.NUM_COEFF(3), .COEFF_W(12), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(z_start), .abort(z_abort),
    .data_in(z_data_in), .data_valid(z_data_valid), .data_ready(z_data_ready),
    .coeff_ld(z_coeff_ld), .coeff_sel(z_coeff_sel), .coeff_in(z_coeff_in),
    .busy(z_busy), .done(z_done), .range_err(z_range_err)
  );

  task automatic test_reset_state();
    @(negedge clk);
    checks++;
    if ({data_ready, coeff_ld, coeff_sel, coeff_in, busy, done, range_err} !== 23'd0) begin
      errors++;
      $display("FAIL reset_state got %h required 0", {data_ready, coeff_ld, coeff_sel, coeff_in, busy, done, range_err});
    end
    checks++;
    if ({z_data_ready, z_coeff_ld, z_coeff_sel, z_coeff_in, z_busy, z_done, z_range_err} !== 23'd0) begin
      errors++;
      $display("FAIL reset_state_gap0 got %h required 0", {z_data_ready, z_coeff_ld, z_coeff_sel, z_coeff_in, z_busy, z_done, z_range_err});
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; data_in = 16'h0ABC; data_valid = 1'b1;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (coeff_ld) seen = 1;
    end
    data_valid = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL reset_preload_timeout got no coeff_ld required one pulse"); end
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (data_ready) seen = 1;
    end
    checks++;
    if (!seen || busy !== 1'b1 || coeff_in !== 16'h0ABC) begin
      errors++;
      $display("FAIL reset_wait_state got ready=%0b busy=%0b in=%h required 1 1 0abc", data_ready, busy, coeff_in);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({data_ready, coeff_ld, coeff_sel, coeff_in, busy, done, range_err} !== 23'd0) begin
      errors++;
      $display("FAIL reset_async got %h required 0", {data_ready, coeff_ld, coeff_sel, coeff_in, busy, done, range_err});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%0b ready=%0b required 0 0", busy, data_ready);
    end
  endtask

  task automatic test_nominal();
    logic [15:0] vals [3];
    exp_t e;
    int k, last_ld, done_cyc, nld;
    bit hs, fin;
    vals = '{16'd1, 16'd2, 16'd3};
    k = 0; last_ld = -100; done_cyc = -1; nld = 0; fin = 0;
    exp_q.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; data_in = vals[0]; data_valid = 1'b1;
    for (int t = 0; t < 40 && !fin; t++) begin
      @(negedge clk);
      hs = data_ready && data_valid;
      if (hs) exp_q.push_back('{cyc, 2'(k), vals[k]});
      if (coeff_ld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL nominal_extra_ld got sel=%0d in=%0d required no pulse", coeff_sel, coeff_in);
        end else begin
          e = exp_q.pop_front();
          if (coeff_sel !== e.sel || coeff_in !== e.val || cyc != e.cyc + 1) begin
            errors++;
            $display("FAIL nominal_ld got sel=%0d in=%0d cyc=%0d required sel=%0d in=%0d cyc=%0d", coeff_sel, coeff_in, cyc, e.sel, e.val, e.cyc + 1);
          end
        end
        if (nld > 0) begin
          checks++;
          if (cyc - last_ld != 3) begin errors++; $display("FAIL nominal_spacing got %0d required 3", cyc - last_ld); end
        end
        last_ld = cyc; nld++;
      end
      if (done) begin
        checks++;
        if (nld != 3 || cyc != last_ld + 1 || busy !== 1'b1 || coeff_sel !== 2'd2 || coeff_in !== 16'd3) begin
          errors++;
          $display("FAIL nominal_done got nld=%0d dly=%0d busy=%0b sel=%0d in=%0d required 3 1 1 2 3", nld, cyc - last_ld, busy, coeff_sel, coeff_in);
        end
        done_cyc = cyc;
      end else if (done_cyc >= 0) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_fall got %0b required 0", busy); end
        fin = 1;
      end
      @(posedge clk); #1;
      if (hs) begin
        k++;
        if (k < 3) data_in = vals[k]; else data_valid = 1'b0;
      end
    end
    checks++;
    if (!fin || nld != 3) begin errors++; $display("FAIL nominal_timeout got pulses=%0d required 3", nld); end
  endtask

  task automatic test_backpressure();
    logic [15:0] vals [3];
    exp_t e;
    int k, nld, stall;
    bit hs, fin;
    vals = '{16'd10, 16'd11, 16'd12};
    k = 0; nld = 0; stall = 0; fin = 0;
    exp_q.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; data_in = vals[0]; data_valid = 1'b1;
    for (int t = 0; t < 40 && !fin; t++) begin
      @(negedge clk);
      if (k == 1 && stall < 4 && (stall > 0 || data_ready)) begin
        checks++;
        if (data_ready !== 1'b1 || coeff_ld !== 1'b0) begin
          errors++; $display("FAIL bp_stall got ready=%0b ld=%0b required 1 0", data_ready, coeff_ld);
        end
        stall++;
      end
      hs = data_ready && data_valid;
      if (hs) exp_q.push_back('{cyc, 2'(k), vals[k]});
      if (coeff_ld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra_ld got sel=%0d in=%0d required no pulse", coeff_sel, coeff_in);
        end else begin
          e = exp_q.pop_front();
          if (coeff_sel !== e.sel || coeff_in !== e.val || cyc != e.cyc + 1) begin
            errors++;
            $display("FAIL bp_ld got sel=%0d in=%0d cyc=%0d required sel=%0d in=%0d cyc=%0d", coeff_sel, coeff_in, cyc, e.sel, e.val, e.cyc + 1);
          end
        end
        nld++;
      end
      if (done) fin = 1;
      @(posedge clk); #1;
      if (hs) begin
        k++;
        if (k < 3) data_in = vals[k];
        data_valid = (k == 2);
      end
      if (k == 1 && stall == 4) data_valid = 1'b1;
    end
    data_valid = 1'b0;
    checks++;
    if (!fin || nld != 3 || stall != 4) begin
      errors++; $display("FAIL bp_timeout got pulses=%0d stalls=%0d required 3 4", nld, stall);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [15:0] vals [3];
    exp_t e;
    int k, nld, after;
    bit hs, fin, st;
    vals = '{16'd68, 16'h1FFF, 16'd5};
    k = 0; nld = 0; after = 0; fin = 0; st = 0;
    exp_q.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; data_in = vals[0]; data_valid = 1'b1;
    for (int t = 0; t < 40 && !fin; t++) begin
      @(negedge clk);
      hs = data_ready && data_valid;
      if (hs) exp_q.push_back('{cyc, 2'(k), (vals[k] > 16'd4095) ? 16'd4095 : vals[k]});
      if (coeff_ld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sat_extra_ld got sel=%0d in=%0d required no pulse", coeff_sel, coeff_in);
        end else begin
          e = exp_q.pop_front();
          if (coeff_sel !== e.sel || coeff_in !== e.val || cyc != e.cyc + 1) begin
            errors++;
            $display("FAIL sat_ld got sel=%0d in=%h cyc=%0d required sel=%0d in=%h cyc=%0d", coeff_sel, coeff_in, cyc, e.sel, e.val, e.cyc + 1);
          end
        end
        nld++;
      end
      if (done || after > 0) begin
        checks++;
        if (range_err !== 1'b1) begin errors++; $display("FAIL sat_range_err got %0b required 1", range_err); end
        after++;
        if (after == 2) fin = 1;
      end
      @(posedge clk); #1;
      if (st) begin start = 1'b0; st = 0; end
      if (hs) begin
        k++;
        if (k < 3) data_in = vals[k]; else data_valid = 1'b0;
        // start arriving mid-sequence must not clear the sticky error
        if (k == 2) begin start = 1'b1; st = 1; end
      end
    end
    checks++;
    if (!fin || nld != 3) begin errors++; $display("FAIL sat_timeout got pulses=%0d required 3", nld); end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (range_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL sat_clear got range_err=%0b busy=%0b required 0 1", range_err, busy);
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic test_abort();
    bit seen, bad;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; data_in = 16'd20; data_valid = 1'b1;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (coeff_ld) seen = 1;
    end
    checks++;
    if (!seen || coeff_sel !== 2'd0 || coeff_in !== 16'd20) begin
      errors++; $display("FAIL abort_slot0 got seen=%0b sel=%0d in=%0d required 1 0 20", seen, coeff_sel, coeff_in);
    end
    @(posedge clk); #1 data_valid = 1'b0; data_in = 16'd21; abort = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || coeff_ld !== 1'b0 || data_ready !== 1'b0) begin
      errors++; $display("FAIL abort_gap got busy=%0b ld=%0b ready=%0b required 1 0 0", busy, coeff_ld, data_ready);
    end
    @(posedge clk); #1 abort = 1'b0; start = 1'b0; data_valid = 1'b1;
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (busy || coeff_ld || done || data_ready) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL abort_idle got activity after abort required busy/ld/done/ready all 0"); end
    @(posedge clk); #1 start = 1'b1; data_valid = 1'b0;
    @(posedge clk); #1 start = 1'b0; data_in = 16'h0777; data_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (coeff_ld !== 1'b0 || busy !== 1'b0 || coeff_in !== 16'd20) begin
      errors++; $display("FAIL abort_vs_handshake got ld=%0b busy=%0b in=%0d required 0 0 20", coeff_ld, busy, coeff_in);
    end
  endtask

  task automatic test_gap0();
    logic [15:0] vals [3];
    exp_t e;
    int k, nld, last_ld;
    bit hs, fin;
    vals = '{16'd7, 16'd8, 16'd9};
    k = 0; nld = 0; last_ld = -100; fin = 0;
    exp_q.delete();
    @(posedge clk); #1 z_start = 1'b1;
    @(posedge clk); #1 z_start = 1'b0; z_data_in = vals[0]; z_data_valid = 1'b1;
    for (int t = 0; t < 30 && !fin; t++) begin
      @(negedge clk);
      hs = z_data_ready && z_data_valid;
      if (hs) exp_q.push_back('{cyc, 2'(k), vals[k]});
      if (z_coeff_ld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL gap0_extra_ld got sel=%0d in=%0d required no pulse", z_coeff_sel, z_coeff_in);
        end else begin
          e = exp_q.pop_front();
          if (z_coeff_sel !== e.sel || z_coeff_in !== e.val || cyc != e.cyc + 1) begin
            errors++;
            $display("FAIL gap0_ld got sel=%0d in=%0d cyc=%0d required sel=%0d in=%0d cyc=%0d", z_coeff_sel, z_coeff_in, cyc, e.sel, e.val, e.cyc + 1);
          end
        end
        if (nld > 0) begin
          checks++;
          if (cyc - last_ld != 2) begin errors++; $display("FAIL gap0_spacing got %0d required 2", cyc - last_ld); end
        end
        last_ld = cyc; nld++;
      end
      if (z_done) begin
        checks++;
        if (cyc != last_ld + 1 || nld != 3) begin
          errors++; $display("FAIL gap0_done got dly=%0d pulses=%0d required 1 3", cyc - last_ld, nld);
        end
        fin = 1;
      end
      @(posedge clk); #1;
      if (hs) begin
        k++;
        if (k < 3) z_data_in = vals[k]; else z_data_valid = 1'b0;
      end
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL gap0_timeout got pulses=%0d required 3 and done", nld); end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0; abort = 1'b0; data_valid = 1'b0; data_in = '0;
    z_start = 1'b0; z_abort = 1'b0; z_data_valid = 1'b0; z_data_in = '0;
    #1 rst = 1'b1;
    test_reset_state();
    test_reset();
    test_nominal();
    test_backpressure();
    test_saturation();
    test_abort();
    test_gap0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
